// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Purpose  : Turns HID key codes written by the Nios II into pedalboard
//            control state: per-effect enables, selected effect, a 4-slot
//            level bank and a global mute. Up/down arrows auto-repeat while
//            held; every other key acts once per press.
// Ports    : clk        - system clock (Avalon fabric domain)
//            reset_n    - asynchronous active-low reset, synchronous release
//            key_code   - HID usage code, 0x00 = no key
//            effect_en  - effect enable bits, bit i = effect i
//            sel        - currently selected effect index
//            levels     - packed level bank, slot i at [i*LEVEL_W +: LEVEL_W]
//            mute       - global output mute
//            key_strobe - one-cycle pulse per accepted action
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl #(
  parameter int LEVEL_W      = 4,
  parameter int LEVEL_INIT   = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_W        = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           key_code,
  output logic [3:0]           effect_en,
  output logic [1:0]           sel,
  output logic [4*LEVEL_W-1:0] levels,
  output logic                 mute,
  output logic                 key_strobe
);

  localparam logic [7:0]         c_key_m     = 8'h10;
  localparam logic [7:0]         c_key_1     = 8'h1E;
  localparam logic [7:0]         c_key_4     = 8'h21;
  localparam logic [7:0]         c_key_down  = 8'h51;
  localparam logic [7:0]         c_key_up    = 8'h52;
  localparam logic [LEVEL_W-1:0] c_level_max = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] c_level_ini = LEVEL_W'(LEVEL_INIT);
  localparam logic [CNT_W-1:0]   c_dly_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   c_rate_last = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_HOLD    = 2'd2,
    ST_REPEAT  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_key_q;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_en, w_en_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic [LEVEL_W-1:0] r_level [4];
  logic [LEVEL_W-1:0] w_level_nxt [4];
  logic               r_mute, w_mute_nxt;
  logic               r_strobe;

  logic       w_new_press;
  logic       w_held;
  logic       w_is_arrow;
  logic       w_rep_fire;
  logic       w_act;
  logic [1:0] w_digit;

  assign w_new_press = (key_code != 8'h00) && (key_code != r_key_q);
  assign w_held      = (key_code != 8'h00) && (key_code == r_key_q);
  assign w_is_arrow  = (key_code == c_key_up) || (key_code == c_key_down);
  // Repeats only fire while the same key stays down; a code change takes the
  // new-press path instead, so a repeat due in that cycle is dropped.
  assign w_rep_fire  = w_held &&
                       (((r_state == ST_HOLD)   && (r_cnt == c_dly_last)) ||
                        ((r_state == ST_REPEAT) && (r_cnt == c_rate_last)));
  assign w_act       = w_new_press || w_rep_fire;
  // '1'..'4' are 0x1E..0x21; the low two bits plus 2 give the index mod 4.
  assign w_digit     = key_code[1:0] + 2'd2;

  // Next-state and counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (key_code == 8'h00) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_new_press) begin
      w_state_nxt = w_is_arrow ? ST_HOLD : ST_LATCHED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == c_dly_last) begin
            w_state_nxt = ST_REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (r_cnt == c_rate_last) w_cnt_nxt = '0;
          else                      w_cnt_nxt = r_cnt + 1'b1;
        end
        default: begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
        end
      endcase
    end
  end

  // Key action decode
  always_comb begin
    w_en_nxt   = r_en;
    w_sel_nxt  = r_sel;
    w_mute_nxt = r_mute;
    for (int i = 0; i < 4; i++) w_level_nxt[i] = r_level[i];
    if (w_act) begin
      if ((key_code >= c_key_1) && (key_code <= c_key_4)) begin
        w_en_nxt[w_digit] = ~r_en[w_digit];
        w_sel_nxt         = w_digit;
      end else if (key_code == c_key_m) begin
        w_mute_nxt = ~r_mute;
      end else if (key_code == c_key_up) begin
        if (r_level[r_sel] != c_level_max)
          w_level_nxt[r_sel] = r_level[r_sel] + 1'b1;
      end else if (key_code == c_key_down) begin
        if (r_level[r_sel] != '0)
          w_level_nxt[r_sel] = r_level[r_sel] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_key_q  <= 8'h00;
      r_cnt    <= '0;
      r_en     <= 4'h0;
      r_sel    <= 2'd0;
      r_mute   <= 1'b0;
      r_strobe <= 1'b0;
      for (int i = 0; i < 4; i++) r_level[i] <= c_level_ini;
    end else begin
      r_state  <= w_state_nxt;
      r_key_q  <= key_code;
      r_cnt    <= w_cnt_nxt;
      r_en     <= w_en_nxt;
      r_sel    <= w_sel_nxt;
      r_mute   <= w_mute_nxt;
      r_strobe <= w_act;
      for (int i = 0; i < 4; i++) r_level[i] <= w_level_nxt[i];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
      assign levels[gi*LEVEL_W +: LEVEL_W] = r_level[gi];
    end
  endgenerate

  assign effect_en  = r_en;
  assign sel        = r_sel;
  assign mute       = r_mute;
  assign key_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_ctrl
// Purpose  : Self-checking bench for key_event_ctrl. A reference model counts
//            edges since each arrow press and predicts the outputs after every
//            clock; predictions are queued at drive time and compared once the
//            edge has happened.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

  localparam int LEVEL_W    = 4;
  localparam int LEVEL_INIT = 8;
  localparam int DELAY      = 8;
  localparam int RATE       = 4;
  localparam int CNT_W      = 25;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [7:0]           key_code;
  logic [3:0]           effect_en;
  logic [1:0]           sel;
  logic [4*LEVEL_W-1:0] levels;
  logic                 mute;
  logic                 key_strobe;

  key_event_ctrl #(
    .LEVEL_W(LEVEL_W), .LEVEL_INIT(LEVEL_INIT), .REPEAT_DELAY(DELAY),
    .REPEAT_RATE(RATE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_code(key_code),
    .effect_en(effect_en), .sel(sel), .levels(levels),
    .mute(mute), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [1:0]  sel;
    logic [15:0] lv;
    logic        mute;
    logic        strobe;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  // Reference model state
  logic [3:0] m_en;
  int         m_sel;
  int         m_lv [4];
  logic       m_mute;
  logic       m_strobe;
  logic [7:0] m_prev;
  int         m_age;   // edges since the current arrow press, -1 if none

  function automatic void model_reset();
    m_en = 4'h0; m_sel = 0; m_mute = 1'b0; m_strobe = 1'b0;
    m_prev = 8'h00; m_age = -1;
    for (int i = 0; i < 4; i++) m_lv[i] = LEVEL_INIT;
  endfunction

  function automatic void model_act(input logic [7:0] k);
    if (k >= 8'h1E && k <= 8'h21) begin
      m_sel = int'(k) - 'h1E;
      m_en[m_sel] = ~m_en[m_sel];
    end else if (k == 8'h10) m_mute = ~m_mute;
    else if (k == 8'h52) begin
      if (m_lv[m_sel] < (1 << LEVEL_W) - 1) m_lv[m_sel] = m_lv[m_sel] + 1;
    end else if (k == 8'h51) begin
      if (m_lv[m_sel] > 0) m_lv[m_sel] = m_lv[m_sel] - 1;
    end
  endfunction

  function automatic void model_step(input logic [7:0] k);
    m_strobe = 1'b0;
    if (k == 8'h00) m_age = -1;
    else if (k != m_prev) begin
      model_act(k);
      m_strobe = 1'b1;
      m_age = (k == 8'h52 || k == 8'h51) ? 0 : -1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == DELAY || (m_age > DELAY && ((m_age - DELAY) % RATE) == 0)) begin
        model_act(k);
        m_strobe = 1'b1;
      end
    end
    m_prev = k;
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    e.en = m_en; e.sel = 2'(m_sel); e.mute = m_mute; e.strobe = m_strobe;
    for (int i = 0; i < 4; i++) e.lv[i*4 +: 4] = 4'(m_lv[i]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("effect_en",  32'(effect_en),  32'(e.en));
      check("sel",        32'(sel),        32'(e.sel));
      check("levels",     32'(levels),     32'(e.lv));
      check("mute",       32'(mute),       32'(e.mute));
      check("key_strobe", 32'(key_strobe), 32'(e.strobe));
    end
    if (key_strobe === 1'b1) strobe_cnt++;
  endtask

  // One clock with key k driven; prediction queued at drive time.
  task automatic tick(input logic [7:0] k);
    @(negedge clk);
    key_code = k;
    model_step(k);
    sb_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic reset_cycle(input logic [7:0] k);
    @(negedge clk);
    key_code = k;
    reset_n  = 1'b0;
    model_reset();
    sb_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    reset_n  = 1'b0;
    key_code = 8'h00;
    model_reset();

    // 1. Reset values
    reset_cycle(8'h00);
    reset_cycle(8'h00);
    #3 reset_n = 1'b1;
    tick(8'h00);

    // 2. '2' pressed for 3 cycles, released, pressed again
    strobe_cnt = 0;
    tick(8'h1F);
    check("t2_en_first",  32'(effect_en), 32'h2);
    check("t2_sel_first", 32'(sel),       32'd1);
    tick(8'h1F); tick(8'h1F); tick(8'h00);
    tick(8'h1F);
    check("t2_en_second", 32'(effect_en), 32'h0);
    tick(8'h00);
    check("t2_strobes", 32'(strobe_cnt), 32'd2);

    // 3. Up arrow held: press edge plus 20 hold edges on slot 1
    strobe_cnt = 0;
    tick(8'h52);
    check("t3_lv1_press", 32'(levels[7:4]), 32'd9);
    for (int i = 0; i < 20; i++) tick(8'h52);
    check("t3_lv1_final", 32'(levels[7:4]), 32'd13);
    tick(8'h00);
    check("t3_strobes", 32'(strobe_cnt), 32'd5);

    // 4. Down arrow held long enough to saturate at 0
    strobe_cnt = 0;
    for (int i = 0; i < 61; i++) tick(8'h51);
    check("t4_lv1_zero", 32'(levels[7:4]), 32'd0);
    tick(8'h00);
    check("t4_strobes", 32'(strobe_cnt), 32'd15);

    // 5. Up held 6 edges, then direct switch to 'm'
    strobe_cnt = 0;
    for (int i = 0; i < 6; i++) tick(8'h52);
    check("t5_lv1_one", 32'(levels[7:4]), 32'd1);
    tick(8'h10);
    check("t5_mute", 32'(mute), 32'd1);
    for (int i = 0; i < 10; i++) tick(8'h10);
    check("t5_strobes", 32'(strobe_cnt), 32'd2);
    tick(8'h00);

    // Unmapped key, '4', then direct switch to down arrow
    tick(8'h04); tick(8'h00);
    tick(8'h21);
    check("x_sel3", 32'(sel), 32'd3);
    tick(8'h51);
    check("x_lv3_down", 32'(levels[15:12]), 32'd7);
    tick(8'h00);

    // Code change on the edge where a repeat was due: new press wins
    for (int i = 0; i < 8; i++) tick(8'h52);
    tick(8'h51);
    check("x_change_wins", 32'(levels[15:12]), 32'd7);
    for (int i = 0; i < 3; i++) tick(8'h51);
    tick(8'h00);

    // 6. Reset asserted mid-hold, released with the arrow still held
    for (int i = 0; i < 5; i++) tick(8'h52);
    #1 reset_n = 1'b0;
    model_reset();
    sb_q.push_back(model_pack());
    #1 compare_out();
    reset_cycle(8'h52);
    reset_cycle(8'h52);
    #3 reset_n = 1'b1;
    strobe_cnt = 0;
    tick(8'h52);
    check("t6_lv0_press", 32'(levels[3:0]), 32'd9);
    for (int i = 0; i < 8; i++) tick(8'h52);
    check("t6_lv0_repeat", 32'(levels[3:0]), 32'd10);
    check("t6_strobes", 32'(strobe_cnt), 32'd2);
    tick(8'h00);
    tick(8'h00);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so a stalled run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Consumes the 8-bit USB HID key code that the Nios II writes to the key_code PIO output port.
- Turns key presses into pedalboard control state: per-effect enable bits, the currently selected effect, a 4-slot level bank and a global mute.
- Up/down arrow keys auto-repeat while held; all other keys act once per press.
- Sits between the key_code PIO and the audio effect datapath, in the same clock domain as the Avalon fabric.

Parameters:
LEVEL_W, 4, width of each effect level; LEVEL_MAX = 2^LEVEL_W - 1
LEVEL_INIT, 8, reset value of every level slot
REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat (0.5 s at 50 MHz); legal range 2..2^CNT_W-1
REPEAT_RATE, 5000000, cycles between subsequent auto-repeats; legal range 2..2^CNT_W-1
CNT_W, 25, width of the hold/repeat counter

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
key_code  in  8  HID usage code from the PIO; 0x00 = no key; synchronous to clk
effect_en  out  4  effect enable bits, bit i = effect i
sel  out  2  currently selected effect index
levels  out  4*LEVEL_W  packed levels; slot i is levels[i*LEVEL_W +: LEVEL_W]
mute  out  1  global output mute
key_strobe  out  1  one-cycle pulse on every accepted action (new press or auto-repeat)

Behaviour:
- Reset (async assert, sync release): effect_en=0, sel=0, every level slot=LEVEL_INIT, mute=0, key_strobe=0, key_q=0x00, counter=0, state=IDLE.
- key_q holds the last sampled key_code; it is loaded every cycle.
- New press: key_code != 0 and key_code != key_q in a cycle.
  - The action's outputs and key_strobe update at the next clk edge (1-cycle latency).
  - key_strobe deasserts on the following edge unless another action occurs.
- Key map:
  - 0x1E..0x21 ('1'..'4'): toggle effect_en[k] and set sel=k, where k = code-0x1E.
  - 0x10 ('m'): toggle mute.
  - 0x52 (up): levels[sel] += 1, saturating at LEVEL_MAX.
  - 0x51 (down): levels[sel] -= 1, saturating at 0.
  - Any other nonzero code: no state change, but key_strobe still pulses.
  - A saturated up/down still pulses key_strobe.
- FSM states:
  - IDLE: waiting for a new press.
    - Arrow press -> HOLD, counter cleared.
    - Non-arrow press -> LATCHED.
  - LATCHED: non-repeating key is held; no further actions.
    - key_code==0 -> IDLE.
    - Different nonzero code -> treated as a new press; state chosen as from IDLE.
  - HOLD: counter increments each cycle while key_code==key_q.
    - On the cycle the counter reaches REPEAT_DELAY-1: repeat the action, pulse key_strobe, clear counter, -> REPEAT.
  - REPEAT: same, but fires every REPEAT_RATE cycles; stays in REPEAT.
- Release (key_code==0) from any state -> IDLE next edge, counter cleared, no action.
- A code change while in HOLD/REPEAT is a new press: its action fires, the counter clears, and state is chosen as from IDLE. A repeat due in the same cycle is suppressed; the new press wins.
- sel changes only on '1'..'4'. An arrow held across a sel change cannot occur, since a sel change requires a different key.
- Counter never wraps: it clears on every fire, release or code change.
- Reset asserted mid-hold aborts immediately to reset values; no action fires on release of reset, even if key_code is nonzero. key_q is 0 after reset, so a key still held at release counts as a new press on the first active cycle.

Test Plan:
Bench parameters: REPEAT_DELAY=8, REPEAT_RATE=4, LEVEL_W=4, LEVEL_INIT=8.
1. Reset with key_code=0 -> effect_en=0, sel=0, all levels=8, mute=0, key_strobe=0.
2. key_code 0x1F for 3 cycles, then 0x00, then 0x1F for 1 cycle -> effect_en=0b0010 and sel=1 after the first press, effect_en=0b0000 after the second; exactly two key_strobe pulses.
3. sel=1, hold 0x52 for 20 cycles -> level1: 9 at the press; 10 at cycle 8 of hold; 11 at cycle 12; 12 at cycle 16; 13 at cycle 20; five key_strobe pulses total.
4. Hold 0x51 from level 1 for 40 cycles -> level reaches 0 and stays 0; key_strobe keeps pulsing on the repeat schedule.
5. Hold 0x52 for 6 cycles, then switch directly to 0x10 -> one up action, then mute=1 one cycle after the switch; no repeat fires; state LATCHED, counter 0.
6. Hold 0x52, assert reset_n=0 at cycle 5 of hold, release while still holding 0x52 -> all outputs return to reset values immediately; one up action fires one cycle after release (level 9); repeat timing restarts from 0.
